generic_bram_fifo: RTL and testbench
====================================

Name: generic_bram_fifo

Overview:
- Initiator-side controller for a dual-port generic BRAM. Turns it into a valid/ready FIFO: port A is write-only, port B is read-only.
- Hides the BRAM's 1-cycle read latency with a 2-entry output buffer, so out_dat always comes straight from a flop.
- The BRAM is instantiated by the parent with HOLD_DOUT=0 and COLLISION="DEFER_WRITE". The controller never issues same-address read/write in one cycle, so the collision policy does not matter.

Parameters:
- WORD_W, 32, data width in bits.
- WORDS_N, 256, BRAM depth; must be a power of two and at least 2 (elaboration error otherwise).
- ADDR_W, $clog2(WORDS_N), localparam, BRAM address width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  push request.
- in_dat  in  WORD_W  push data.
- in_rdy  out  1  push accepted when in_vld & in_rdy.
- out_vld  out  1  head entry valid.
- out_dat  out  WORD_W  head data (registered).
- out_rdy  in  1  pop when out_vld & out_rdy.
- level  out  ADDR_W+2  total entries held (BRAM + in-flight + buffer), range 0..WORDS_N+2.
- cea  out  1  BRAM port A enable.
- addra  out  ADDR_W  port A address.
- dina  out  WORD_W  port A write data.
- rnwa  out  1  port A read-not-write; tied 0.
- ceb  out  1  BRAM port B enable.
- addrb  out  ADDR_W  port B address.
- dinb  out  WORD_W  tied 0.
- rnwb  out  1  tied 1.
- doutb  in  WORD_W  port B read data, valid 1 cycle after ceb.

Behaviour:
- State: wptr and rptr (ADDR_W+1 bits each, wrap naturally); occ = wptr - rptr; rd_inflight flag; output buffer of 2 entries with a 0..2 count.
- Reset: wptr=rptr=0, rd_inflight=0, buffer empty. Outputs out_vld=0, level=0, in_rdy=0, cea=ceb=0 while rst is high. BRAM contents are not cleared.
- Reset mid-operation: all in-flight and buffered data are discarded; no read capture occurs in the cycle after rst deasserts.
- Push:
  - in_rdy = !rst & (occ != WORDS_N).
  - On accept, same cycle (combinational): cea=1, addra=wptr[ADDR_W-1:0], dina=in_dat. wptr increments at the edge.
- Read issue: ceb=1, addrb=rptr[ADDR_W-1:0] when occ != 0 and (buf_count + rd_inflight - pop) < 2, where pop = out_vld & out_rdy. rptr increments at the edge; rd_inflight <= ceb.
- Capture: when rd_inflight=1, doutb is written into the buffer at the end of that cycle.
- Collision freedom: occ counts only writes from prior cycles, so a read never targets the address being written this cycle.
- Buffer ordering: out_dat is always the oldest entry; out_vld = (buf_count != 0).
- Simultaneous pop and capture: count is unchanged and order is preserved.
- Simultaneous push and pop: both proceed; level = level + push - pop.
- Latency, empty FIFO, no bypass: push at cycle N -> read issued at N+1 -> capture at end of N+2 -> out_vld at N+3.
- Throughput: sustained 1 push and 1 pop per cycle with out_rdy held high.
- Full: occ == WORDS_N gives in_rdy=0; the 2 buffer slots are additional capacity.
- Wrap-around: pointer MSBs distinguish full from empty; addresses wrap from WORDS_N-1 to 0.

Optional Feature:
- Macro: GENERIC_BRAM_FIFO_BYPASS_EN.
- Defined: when occ==0, rd_inflight==0 and buffer room is available after this cycle's pop, an accepted push is written directly into the output buffer and the BRAM is not written. out_vld rises the next cycle (latency 1). Ordering is preserved because bypass is only permitted when the BRAM and pipeline are empty.
- Undefined: every push goes through the BRAM (latency 3).

Decomposition:
- Package generic_bram_fifo_pkg: OBUF_N=2 constant, BRAM_RD_LAT=1 constant, ptr_t/level_t widths as parameterized function helpers.
- Sub-module generic_bram_fifo_obuf: 2-entry registered FIFO (push/pop/count, WORD_W param) used for the output buffer.

Test Plan:
- Reset then single push 0xA5A5_0001 with out_rdy=1 -> ceb at cycle+1, out_vld at cycle+3 with out_dat=0xA5A5_0001, level back to 0 after pop.
- WORDS_N=8, out_rdy=0, push 12 words -> ten accepted (8 BRAM + 2 buffer); in_rdy=0 thereafter; level=10; drain returns values 0..9 in order.
- Continuous push/pop of 1000 incrementing words, out_rdy=1 -> one pop per cycle after fill latency, no gaps, no reorder, pointers wrap many times.
- Random out_rdy at 30% with random in_vld -> scoreboard order match; ceb never high when buf_count + rd_inflight - pop >= 2; never addra==addrb with cea&ceb.
- Assert rst while 5 entries are held and a read is in flight -> next cycle out_vld=0, level=0; a subsequent push 0x1234 pops as 0x1234 only.
- With GENERIC_BRAM_FIFO_BYPASS_EN, push to empty -> out_vld next cycle, cea stays 0; without the macro -> 3-cycle latency and cea=1.

Source files
------------

// File: rtl/generic_bram_fifo_pkg.sv
// generic_bram_fifo_pkg
// Shared constants and width helpers for the BRAM-backed valid/ready FIFO.
//   OBUF_N      : depth of the registered output buffer behind the BRAM.
//   BRAM_RD_LAT : BRAM port B read latency the controller is built around.
//   ptr_w()     : read/write pointer width (address bits plus wrap bit).
//   level_w()   : width of the total-occupancy count (covers WORDS_N + OBUF_N).
package generic_bram_fifo_pkg;

  localparam int OBUF_N      = 2;
  localparam int BRAM_RD_LAT = 1;

  function automatic int ptr_w(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int level_w(input int words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/generic_bram_fifo_obuf.sv
// generic_bram_fifo_obuf
// Two-entry registered FIFO that sits behind the BRAM read port so the head
// word is always presented from a flop.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset (count only)
//   push      : write push_dat (caller guarantees room after this cycle's pop)
//   push_dat  : word to append
//   pop       : drop the head entry (caller guarantees count != 0)
//   head_dat  : oldest entry
//   count     : number of valid entries, 0..OBUF_N
module generic_bram_fifo_obuf
  import generic_bram_fifo_pkg::*;
#(
  parameter int WORD_W = 32,
  localparam int CNT_W = $clog2(OBUF_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_dat,
  input  logic              pop,
  output logic [WORD_W-1:0] head_dat,
  output logic [CNT_W-1:0]  count
);

  logic [WORD_W-1:0] slot0;
  logic [WORD_W-1:0] slot1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data slots carry no reset; validity is tracked by count alone.
  // slot0 is always the head, so a pop shifts slot1 forward and a
  // simultaneous push lands behind whatever remains.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (push && count == CNT_W'(1)) slot0 <= push_dat;
      else                            slot0 <= slot1;
      if (push && count == CNT_W'(2)) slot1 <= push_dat;
    end else if (push) begin
      if (count == '0) slot0 <= push_dat;
      else             slot1 <= push_dat;
    end
  end

  assign head_dat = slot0;

endmodule

// File: rtl/generic_bram_fifo.sv
// generic_bram_fifo
// Initiator-side controller turning a dual-port generic BRAM (port A write,
// port B read, 1-cycle read latency) into a valid/ready FIFO. A 2-entry
// output buffer hides the read latency and keeps out_dat registered.
// Optional build macro: GENERIC_BRAM_FIFO_BYPASS_EN -- when the BRAM and the
// read pipe are empty, a push goes straight into the output buffer.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_vld/in_dat/in_rdy        : push side
//   out_vld/out_dat/out_rdy     : pop side (out_dat from a flop)
//   level                       : entries held in BRAM + read pipe + buffer
//   cea/addra/dina/rnwa         : BRAM port A (write only)
//   ceb/addrb/dinb/rnwb/doutb   : BRAM port B (read only)
module generic_bram_fifo
  import generic_bram_fifo_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int WORDS_N = 256,
  localparam int ADDR_W = $clog2(WORDS_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [WORD_W-1:0] in_dat,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [WORD_W-1:0] out_dat,
  input  logic              out_rdy,
  output logic [ADDR_W+1:0] level,
  output logic              cea,
  output logic [ADDR_W-1:0] addra,
  output logic [WORD_W-1:0] dina,
  output logic              rnwa,
  output logic              ceb,
  output logic [ADDR_W-1:0] addrb,
  output logic [WORD_W-1:0] dinb,
  output logic              rnwb,
  input  logic [WORD_W-1:0] doutb
);

  localparam int PTR_W = ptr_w(WORDS_N);
  localparam int LVL_W = level_w(WORDS_N);

  if (WORDS_N < 2 || (WORDS_N & (WORDS_N - 1)) != 0) begin : g_bad_depth
    $error("generic_bram_fifo: WORDS_N must be a power of two >= 2");
  end
  if (BRAM_RD_LAT != 1) begin : g_bad_lat
    $error("generic_bram_fifo: read pipe is built for a 1-cycle BRAM");
  end

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  occ;
  logic              rd_inflight;
  logic [1:0]        buf_count;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              rd_issue;
  logic [2:0]        room_need;
  logic              obuf_push;
  logic [WORD_W-1:0] obuf_dat;

  // occ only sees writes committed in earlier cycles, so a read never hits
  // the address being written in the same cycle.
  assign occ       = wptr - rptr;
  assign out_vld   = !rst && (buf_count != '0);
  assign pop       = out_vld && out_rdy;
  assign in_rdy    = !rst && (occ != PTR_W'(WORDS_N));
  assign push      = in_vld && in_rdy;
  assign room_need = {1'b0, buf_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue  = !rst && (occ != '0) && (room_need < 3'd2);

`ifdef GENERIC_BRAM_FIFO_BYPASS_EN
  // With nothing in the BRAM or read pipe, ordering cannot be violated by
  // skipping the BRAM.
  assign bypass = push && (occ == '0) && !rd_inflight && (room_need < 3'd2);
`else
  assign bypass = 1'b0;
`endif

  // Stage 0: write port A / issue read on port B
  assign cea   = push && !bypass;
  assign addra = wptr[ADDR_W-1:0];
  assign dina  = in_dat;
  assign rnwa  = 1'b0;
  assign ceb   = rd_issue;
  assign addrb = rptr[ADDR_W-1:0];
  assign dinb  = '0;
  assign rnwb  = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (cea)      wptr <= wptr + PTR_W'(1);
      if (rd_issue) rptr <= rptr + PTR_W'(1);
      rd_inflight <= rd_issue;
    end
  end

  // Stage 1: BRAM data returns and is captured into the output buffer
  assign obuf_push = rd_inflight || bypass;
  assign obuf_dat  = rd_inflight ? doutb : in_dat;

  generic_bram_fifo_obuf #(.WORD_W(WORD_W)) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push     (obuf_push),
    .push_dat (obuf_dat),
    .pop      (pop),
    .head_dat (out_dat),
    .count    (buf_count)
  );

  assign level = rst ? '0
                     : LVL_W'(occ) + LVL_W'(rd_inflight) + LVL_W'(buf_count);

endmodule

// File: tb/tb_generic_bram_fifo.sv
module tb_generic_bram_fifo;

  localparam int WORD_W  = 32;
  localparam int WORDS_N = 8;
  localparam int ADDR_W  = 3;
`ifdef GENERIC_BRAM_FIFO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic              clk;
  logic              rst;
  logic              in_vld;
  logic [WORD_W-1:0] in_dat;
  logic              in_rdy;
  logic              out_vld;
  logic [WORD_W-1:0] out_dat;
  logic              out_rdy;
  logic [ADDR_W+1:0] level;
  logic              cea;
  logic [ADDR_W-1:0] addra;
  logic [WORD_W-1:0] dina;
  logic              rnwa;
  logic              ceb;
  logic [ADDR_W-1:0] addrb;
  logic [WORD_W-1:0] dinb;
  logic              rnwb;
  logic [WORD_W-1:0] doutb;

  generic_bram_fifo #(.WORD_W(WORD_W), .WORDS_N(WORDS_N)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
    .level(level),
    .cea(cea), .addra(addra), .dina(dina), .rnwa(rnwa),
    .ceb(ceb), .addrb(addrb), .dinb(dinb), .rnwb(rnwb), .doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered read, output is junk when port B was idle.
  logic [WORD_W-1:0] mem [WORDS_N];
  always @(posedge clk) begin
    if (cea) mem[addra] <= dina;
    doutb <= ceb ? mem[addrb] : WORD_W'($urandom);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and occupancy model.
  logic [WORD_W-1:0] sb [$];
  int lvl_m = 0, infl_m = 0, buf_m = 0;
  int pop_cnt = 0, first_pop = -1, last_pop = -1;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int occ_m, p, a, byp, rd_m;
    logic [WORD_W-1:0] e;
    if (rst) begin
      check("rst_out_vld", 64'(out_vld), 64'(0));
      check("rst_level",   64'(level),   64'(0));
      check("rst_in_rdy",  64'(in_rdy),  64'(0));
      check("rst_ce",      64'({cea, ceb}), 64'(0));
      sb.delete();
      lvl_m = 0; infl_m = 0; buf_m = 0;
    end else begin
      p     = (out_vld && out_rdy) ? 1 : 0;
      a     = (in_vld && in_rdy) ? 1 : 0;
      occ_m = lvl_m - infl_m - buf_m;
      byp   = (BYP == 1 && a == 1 && occ_m == 0 && infl_m == 0 && (buf_m - p) < 2) ? 1 : 0;
      rd_m  = (occ_m != 0 && (buf_m + infl_m - p) < 2) ? 1 : 0;
      check("level",   64'(level),   64'(lvl_m));
      check("out_vld", 64'(out_vld), 64'(buf_m != 0));
      check("in_rdy",  64'(in_rdy),  64'(occ_m != WORDS_N));
      check("cea",     64'(cea),     64'(a == 1 && byp == 0));
      check("ceb",     64'(ceb),     64'(rd_m));
      if (cea && ceb) check("addr_collide", 64'(addra == addrb), 64'(0));
      if (p == 1) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (sb.size() == 0) check("pop_empty", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          check("out_dat", 64'(out_dat), 64'(e));
        end
      end
      if (a == 1) sb.push_back(in_dat);
      lvl_m  = lvl_m + a - p;
      buf_m  = buf_m + infl_m + byp - p;
      infl_m = rd_m;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) step();
  endtask

  initial begin
    int lat, c1, val, stalls, base;
    rst = 1'b1; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("tie_rnwa", 64'(rnwa), 64'(0));
    check("tie_rnwb", 64'(rnwb), 64'(1));
    check("tie_dinb", 64'(dinb), 64'(0));

    // Single push latency
    step();
    in_vld = 1'b1; in_dat = 32'hA5A5_0001; out_rdy = 1'b1;
    @(negedge clk);
    check("t1_cea", 64'(cea), 64'(BYP == 0));
    step();
    in_vld = 1'b0;
    lat = -1; c1 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) c1 = ceb ? 1 : 0;
      if (out_vld && lat < 0) lat = k;
    end
    check("t1_ceb_next", 64'(c1), 64'(BYP == 0));
    check("t1_latency", 64'(lat), 64'(BYP == 1 ? 1 : 3));
    check("t1_level_after_pop", 64'(level), 64'(0));

    // Fill to full with out_rdy low
    step();
    out_rdy = 1'b0; val = 0;
    for (int c = 0; c < 30 && val < 12; c++) begin
      in_vld = 1'b1; in_dat = WORD_W'(val);
      @(negedge clk);
      if (in_rdy) val++;
      step();
    end
    in_vld = 1'b0;
    @(negedge clk);
    check("t2_accepted", 64'(val), 64'(10));
    check("t2_in_rdy", 64'(in_rdy), 64'(0));
    check("t2_level", 64'(level), 64'(10));
    step();
    base = pop_cnt; out_rdy = 1'b1;
    drain(40);
    check("t2_drained", 64'(pop_cnt - base), 64'(10));
    check("t2_empty", 64'(sb.size()), 64'(0));

    // Streaming 1000 words
    step();
    base = pop_cnt; first_pop = -1; val = 0; stalls = 0;
    for (int c = 0; c < 1100 && val < 1000; c++) begin
      in_vld = 1'b1; in_dat = 32'h5000_0000 + WORD_W'(val);
      @(negedge clk);
      if (in_rdy) val++;
      else stalls++;
      step();
    end
    in_vld = 1'b0;
    drain(20);
    check("t3_pushed", 64'(val), 64'(1000));
    check("t3_stalls", 64'(stalls), 64'(0));
    check("t3_pops", 64'(pop_cnt - base), 64'(1000));
    check("t3_gapless", 64'(last_pop - first_pop), 64'(999));

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_vld  = ($urandom_range(0, 1) == 1);
      in_dat  = WORD_W'($urandom);
      out_rdy = ($urandom_range(0, 9) < 3);
      step();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    drain(40);
    check("t4_empty", 64'(sb.size()), 64'(0));

    // Reset mid-operation
    step();
    out_rdy = 1'b0; val = 0;
    for (int c = 0; c < 20 && val < 5; c++) begin
      in_vld = 1'b1; in_dat = 32'hC000_0000 + WORD_W'(val);
      @(negedge clk);
      if (in_rdy) val++;
      step();
    end
    in_vld = 1'b0;
    repeat (6) step();
    check("t5_level_held", 64'(level), 64'(5));
    in_vld = 1'b1; in_dat = 32'hC000_00FF; out_rdy = 1'b1;
    @(negedge clk);
    check("t5_read_issued", 64'(ceb), 64'(1));
    step();
    in_vld = 1'b0; out_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t5_level_in_rst", 64'(level), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_vld_after", 64'(out_vld), 64'(0));
    check("t5_level_after", 64'(level), 64'(0));
    repeat (4) step();
    check("t5_no_stale", 64'(out_vld), 64'(0));
    base = pop_cnt;
    in_vld = 1'b1; in_dat = 32'h0000_1234; out_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    drain(10);
    repeat (2) step();
    check("t5_pops", 64'(pop_cnt - base), 64'(1));
    check("t5_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
